// File: rtl/control_seq.sv
// control_seq: sequenced picoMips control unit.
// It keeps an internal instruction stage counter, decodes the func field into
// datapath selects, and qualifies the PC and write strobes with the final stage.
// Handshake instructions stall in a WAIT state until the synchronised switch
// input differs from the instruction's argument bit.
module control_seq #(
  parameter int INSTR_WIDTH    = 13,
  parameter int IMM_BITS       = 6,
  parameter int DATA_WIDTH     = 8,
  parameter int REG_ADDR_WIDTH = 1,
  parameter int NUM_STAGES     = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [INSTR_WIDTH-1:0]        Instruction,
  input  logic                          Handshake,
  output logic [$clog2(NUM_STAGES)-1:0] Stage,
  output logic                          Waiting,
  output logic                          PCEn,
  output logic [DATA_WIDTH-1:0]         Immediate,
  output logic [REG_ADDR_WIDTH-1:0]     RegAddr,
  output logic                          RegWrite,
  output logic                          ACCWE,
  output logic                          UseACC,
  output logic                          SelSW,
  output logic                          SelImm,
  output logic                          UseMul,
  output logic                          SelRegData
);

  localparam int STAGE_W = $clog2(NUM_STAGES);
  localparam logic [STAGE_W-1:0] FINAL_STAGE = STAGE_W'(NUM_STAGES - 1);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  logic [6:0]             func;
  logic [SYNC_STAGES-1:0] hs_sync_reg;
  logic                   hs_s;
  logic                   hs_match;
  logic                   is_final;

  state_t                 state_reg;
  state_t                 state_next;
  logic [STAGE_W-1:0]     stage_reg;
  logic [STAGE_W-1:0]     stage_next;
  logic                   waiting_reg;
  logic                   pc_en_next;
  logic                   acc_we_next;
  logic                   reg_we_next;

  assign func = Instruction[INSTR_WIDTH-1 -: 7];

  // Datapath selects and operand fields come straight from the instruction;
  // they are deliberately not gated by stage or reset.
  assign UseACC     = func[0];
  assign SelSW      = func[1];
  assign SelImm     = func[2];
  assign UseMul     = func[3];
  assign SelRegData = func[6];
  assign Immediate  = DATA_WIDTH'($signed(Instruction[IMM_BITS-1:0]));
  assign RegAddr    = Instruction[REG_ADDR_WIDTH-1:0];

  // Handshake synchroniser chain: flop 0 samples the raw switch, each later
  // flop samples its predecessor, so hs_s lags Handshake by SYNC_STAGES edges.
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_hs_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge Clock) begin
          if (Reset) hs_sync_reg[gi] <= 1'b0;
          else       hs_sync_reg[gi] <= Handshake;
        end
      end else begin : g_rest
        always_ff @(posedge Clock) begin
          if (Reset) hs_sync_reg[gi] <= 1'b0;
          else       hs_sync_reg[gi] <= hs_sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign hs_s     = hs_sync_reg[SYNC_STAGES-1];
  assign hs_match = (hs_s == Instruction[0]);
  assign is_final = (stage_reg == FINAL_STAGE);

  // State, stage counter and registered Waiting flag.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg   <= ST_RUN;
      stage_reg   <= '0;
      waiting_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      stage_reg   <= stage_next;
      waiting_reg <= (state_next == ST_WAIT);
    end
  end

  // Next-state logic and final-stage strobes.
  always_comb begin
    state_next  = state_reg;
    stage_next  = stage_reg;
    pc_en_next  = 1'b0;
    acc_we_next = 1'b0;
    reg_we_next = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (is_final) begin
          acc_we_next = !(func[5] | func[4]);
          reg_we_next = func[4] & !func[5];
          if (func[5] && hs_match) begin
            // Handshake not yet satisfied: park on the final stage.
            state_next = ST_WAIT;
          end else begin
            pc_en_next = 1'b1;
            stage_next = '0;
          end
        end else begin
          stage_next = stage_reg + 1'b1;
        end
      end
      ST_WAIT: begin
        if (!hs_match) begin
          pc_en_next = 1'b1;
          state_next = ST_RUN;
          stage_next = '0;
        end
      end
      default: begin
        state_next = ST_RUN;
        stage_next = '0;
      end
    endcase
  end

  // Strobes are suppressed during reset so a reset landing on the final stage
  // never leaks a PC advance or register/accumulator write.
  assign PCEn     = pc_en_next  & !Reset;
  assign ACCWE    = acc_we_next & !Reset;
  assign RegWrite = reg_we_next & !Reset;
  assign Stage    = stage_reg;
  assign Waiting  = waiting_reg;

endmodule

// File: tb/tb_control_seq.sv
// Self-checking bench for control_seq: default instance plus a 5-stage,
// 16-bit-data instance. Expected status vectors are pushed to a queue as each
// cycle's stimulus is driven and popped when the outputs are sampled.
module tb_control_seq;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [12:0] Instruction = 13'b0000001_000101;
  logic        Handshake = 1'b0;
  logic [1:0]  Stage;
  logic        Waiting, PCEn, RegWrite, ACCWE;
  logic [7:0]  Immediate;
  logic [0:0]  RegAddr;
  logic        UseACC, SelSW, SelImm, UseMul, SelRegData;

  logic [11:0] Instruction5 = {7'b0000001, 5'b10000};
  logic [2:0]  Stage5;
  logic        Waiting5, PCEn5, RegWrite5, ACCWE5;
  logic [15:0] Immediate5;
  logic [0:0]  RegAddr5;
  logic        UseACC5, SelSW5, SelImm5, UseMul5, SelRegData5;

  int n_cmp = 0;
  int n_mis = 0;

  // expected {stage[2:0], waiting, pcen, accwe, regwrite}
  logic [6:0] sb[$];
  logic [6:0] exp_v;
  logic [6:0] obs_v;

  always #5 Clock = ~Clock;

  control_seq u_dut (
    .Clock(Clock), .Reset(Reset), .Instruction(Instruction), .Handshake(Handshake),
    .Stage(Stage), .Waiting(Waiting), .PCEn(PCEn), .Immediate(Immediate),
    .RegAddr(RegAddr), .RegWrite(RegWrite), .ACCWE(ACCWE), .UseACC(UseACC),
    .SelSW(SelSW), .SelImm(SelImm), .UseMul(UseMul), .SelRegData(SelRegData)
  );

  control_seq #(
    .INSTR_WIDTH(12), .IMM_BITS(5), .DATA_WIDTH(16), .REG_ADDR_WIDTH(1),
    .NUM_STAGES(5), .SYNC_STAGES(2)
  ) u_dut5 (
    .Clock(Clock), .Reset(Reset), .Instruction(Instruction5), .Handshake(Handshake),
    .Stage(Stage5), .Waiting(Waiting5), .PCEn(PCEn5), .Immediate(Immediate5),
    .RegAddr(RegAddr5), .RegWrite(RegWrite5), .ACCWE(ACCWE5), .UseACC(UseACC5),
    .SelSW(SelSW5), .SelImm(SelImm5), .UseMul(UseMul5), .SelRegData(SelRegData5)
  );

  function automatic logic [6:0] obs_main();
    return {1'b0, Stage, Waiting, PCEn, ACCWE, RegWrite};
  endfunction

  // Pulse reset for one edge; returns on a falling edge with reset released.
  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Instruction = 13'b0000001_000101;
    Handshake = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    sb.push_back(7'b000_0_000);
    #1;
    exp_v = sb.pop_front();
    obs_v = obs_main();
    n_cmp++;
    if (obs_v !== exp_v) begin
      n_mis++;
      $display("FAIL reset_state: got %b expected %b", obs_v, exp_v);
    end
    Reset = 1'b0;
    @(negedge Clock);
  endtask

  task automatic test_acc_instr();
    Instruction = 13'b0000001_000101;
    Handshake = 1'b0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      sb.push_back({1'b0, 2'(i % 4), 1'b0, (i % 4 == 3), (i % 4 == 3), 1'b0});
      #1;
      exp_v = sb.pop_front();
      obs_v = obs_main();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_mis++;
        $display("FAIL acc_cycle%0d: got %b expected %b", i, obs_v, exp_v);
      end
      @(negedge Clock);
    end
    n_cmp++;
    if (Immediate !== 8'h05) begin
      n_mis++;
      $display("FAIL acc_imm: got %h expected 05", Immediate);
    end
  endtask

  task automatic test_regwrite_instr();
    Instruction = 13'b0010000_111110;
    Handshake = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      sb.push_back({1'b0, 2'(i % 4), 1'b0, (i % 4 == 3), 1'b0, (i % 4 == 3)});
      #1;
      exp_v = sb.pop_front();
      obs_v = obs_main();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_mis++;
        $display("FAIL regw_cycle%0d: got %b expected %b", i, obs_v, exp_v);
      end
      @(negedge Clock);
    end
    n_cmp++;
    if (Immediate !== 8'hFE || RegAddr !== 1'b0) begin
      n_mis++;
      $display("FAIL regw_fields: got imm=%h addr=%b expected imm=fe addr=0", Immediate, RegAddr);
    end
  endtask

  task automatic test_decode();
    logic [4:0] sel;
    Instruction = 13'b1001110_100001;
    #1;
    sel = {SelRegData, UseMul, SelImm, SelSW, UseACC};
    n_cmp++;
    if (sel !== 5'b11110 || Immediate !== 8'hE1 || RegAddr !== 1'b1) begin
      n_mis++;
      $display("FAIL decode_a: got sel=%b imm=%h addr=%b expected sel=11110 imm=e1 addr=1",
               sel, Immediate, RegAddr);
    end
    Instruction = 13'b0000001_011111;
    #1;
    sel = {SelRegData, UseMul, SelImm, SelSW, UseACC};
    n_cmp++;
    if (sel !== 5'b00001 || Immediate !== 8'h1F) begin
      n_mis++;
      $display("FAIL decode_b: got sel=%b imm=%h expected sel=00001 imm=1f", sel, Immediate);
    end
    @(negedge Clock);
  endtask

  task automatic test_wait();
    logic [6:0] tbl [7];
    tbl = '{7'b011_1_000, 7'b011_1_000, 7'b011_1_100, 7'b000_0_000,
            7'b001_0_000, 7'b010_0_000, 7'b011_0_100};
    Instruction = 13'b0100000_000001;
    Handshake = 1'b1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      sb.push_back({1'b0, (i < 4) ? 2'(i) : 2'd3, (i >= 4), 3'b000});
      #1;
      exp_v = sb.pop_front();
      obs_v = obs_main();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_mis++;
        $display("FAIL wait_hold%0d: got %b expected %b", i, obs_v, exp_v);
      end
      @(negedge Clock);
    end
    Handshake = 1'b0;
    for (int k = 0; k < 7; k++) begin
      sb.push_back(tbl[k]);
      #1;
      exp_v = sb.pop_front();
      obs_v = obs_main();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_mis++;
        $display("FAIL wait_release%0d: got %b expected %b", k, obs_v, exp_v);
      end
      @(negedge Clock);
    end
  endtask

  task automatic test_handshake_nowait();
    Instruction = 13'b0100000_000001;
    Handshake = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      sb.push_back({1'b0, 2'(i % 4), 1'b0, (i % 4 == 3), 2'b00});
      #1;
      exp_v = sb.pop_front();
      obs_v = obs_main();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_mis++;
        $display("FAIL nowait_cycle%0d: got %b expected %b", i, obs_v, exp_v);
      end
      @(negedge Clock);
    end
  endtask

  // Reset during WAIT, at stage 2 and at the final stage: the reset cycle and
  // the first cycle after it must carry no strobes.
  task automatic test_reset_midway();
    logic [6:0] tbl [6];
    Instruction = 13'b0100000_000001;
    Handshake = 1'b1;
    do_reset();
    repeat (6) @(negedge Clock);
    tbl = '{7'b011_1_000, 7'b000_0_000, 7'b001_0_000,
            7'b000_0_000, 7'b000_0_000, 7'b001_0_000};
    Reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sb.push_back(tbl[k]);
      #1;
      exp_v = sb.pop_front();
      obs_v = obs_main();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_mis++;
        $display("FAIL rst_wait%0d: got %b expected %b", k, obs_v, exp_v);
      end
      @(negedge Clock);
      Reset = 1'b0;
    end
    for (int s = 2; s <= 3; s++) begin
      Instruction = 13'b0000001_000101;
      Handshake = 1'b0;
      do_reset();
      repeat (s) @(negedge Clock);
      Reset = 1'b1;
      tbl[0] = {1'b0, 2'(s), 4'b0000};
      for (int k = 0; k < 3; k++) begin
        sb.push_back((k == 0) ? tbl[0] : tbl[k + 3]);
        #1;
        exp_v = sb.pop_front();
        obs_v = obs_main();
        n_cmp++;
        if (obs_v !== exp_v) begin
          n_mis++;
          $display("FAIL rst_stage%0d_%0d: got %b expected %b", s, k, obs_v, exp_v);
        end
        @(negedge Clock);
        Reset = 1'b0;
      end
    end
  endtask

  task automatic test_param_override();
    Instruction5 = {7'b0000001, 5'b10000};
    Handshake = 1'b0;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      sb.push_back({3'(i % 5), 1'b0, (i % 5 == 4), (i % 5 == 4), 1'b0});
      #1;
      exp_v = sb.pop_front();
      obs_v = {Stage5, Waiting5, PCEn5, ACCWE5, RegWrite5};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_mis++;
        $display("FAIL p5_cycle%0d: got %b expected %b", i, obs_v, exp_v);
      end
      @(negedge Clock);
    end
    n_cmp++;
    if (Immediate5 !== 16'hFFF0) begin
      n_mis++;
      $display("FAIL p5_imm: got %h expected fff0", Immediate5);
    end
  endtask

  initial begin
    test_reset();
    test_acc_instr();
    test_regwrite_instr();
    test_decode();
    test_wait();
    test_handshake_nowait();
    test_reset_midway();
    test_param_override();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
